// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants: ALU op codes, opcodes, funct3/funct7 values
// and the decoded-instruction record handed from decode to execute.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_EQL  = 4'd10;
  localparam logic [3:0] ALU_NEQ  = 4'd11;
  localparam logic [3:0] ALU_GTE  = 4'd12;
  localparam logic [3:0] ALU_GTEU = 4'd13;
  localparam logic [3:0] ALU_NOP  = 4'd14;
  localparam logic [3:0] ALU_ERR  = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        rd_we;
    logic        is_branch;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } dec_t;

  // alt selects SUB over ADD and SRA over SRL (instr[30])
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_stage_imm_gen.sv
// RV32I immediate extraction; all immediates sign-extended from instr[31].
module imm_gen (
  input  logic [31:7] instr_i,
  output logic [31:0] imm_i_o,
  output logic [31:0] imm_s_o,
  output logic [31:0] imm_b_o,
  output logic [31:0] imm_u_o
);

  assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u_o = {instr_i[31:12], 12'b0};

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage feeding the ALU: decodes one RV32I instruction into an
// ALU op plus operands and holds it in a single valid/ready output register.
module decode_issue_stage
  import cpu_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_in_1,
  output logic [XLEN-1:0] alu_in_2,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            is_branch,
  output logic            mem_read,
  output logic            mem_write,
  output logic            illegal
);

  localparam dec_t DEC_RST = '{alu_op: ALU_NOP, default: '0};

  logic [31:0] imm_i, imm_s, imm_u;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        shift_f3;
  dec_t        dec_d, dec_q;
  logic        valid_q;
  logic [XLEN-1:0] pc_q, store_q;
  logic [4:0]  rd_q;
  logic        load;

  imm_gen u_imm_gen (
    .instr_i (instr[31:7]),
    .imm_i_o (imm_i),
    .imm_s_o (imm_s),
    .imm_b_o (),
    .imm_u_o (imm_u)
  );

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign shift_f3 = (f3 == F3_SLL) || (f3 == F3_SR);

  // Default is the illegal encoding; each legal path clears illegal.
  always_comb begin
    dec_d         = '0;
    dec_d.alu_op  = ALU_ERR;
    dec_d.in_1    = rs1_data;
    dec_d.in_2    = rs2_data;
    dec_d.illegal = 1'b1;
    case (opcode)
      OP_R: begin
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
          dec_d.alu_op  = alu_from_f3(f3, instr[30]);
          dec_d.in_2    = shift_f3 ? {27'b0, rs2_data[4:0]} : rs2_data;
          dec_d.rd_we   = 1'b1;
          dec_d.illegal = 1'b0;
        end
      end
      OP_I: begin
        if (!shift_f3 || f7 == F7_BASE || (f3 == F3_SR && f7 == F7_ALT)) begin
          dec_d.alu_op  = alu_from_f3(f3, shift_f3 && instr[30]);
          dec_d.in_2    = shift_f3 ? {27'b0, instr[24:20]} : imm_i;
          dec_d.rd_we   = 1'b1;
          dec_d.illegal = 1'b0;
        end
      end
      OP_LUI, OP_AUIPC: begin
        dec_d.alu_op  = ALU_ADD;
        dec_d.in_1    = (opcode == OP_AUIPC) ? pc : '0;
        dec_d.in_2    = imm_u;
        dec_d.rd_we   = 1'b1;
        dec_d.illegal = 1'b0;
      end
      OP_LOAD: begin
        dec_d.alu_op   = ALU_ADD;
        dec_d.in_2     = imm_i;
        dec_d.mem_read = 1'b1;
        dec_d.rd_we    = 1'b1;
        dec_d.illegal  = 1'b0;
      end
      OP_STORE: begin
        dec_d.alu_op    = ALU_ADD;
        dec_d.in_2      = imm_s;
        dec_d.mem_write = 1'b1;
        dec_d.illegal   = 1'b0;
      end
      OP_BRANCH: begin
        if (f3 != F3_SLT && f3 != F3_SLTU) begin
          case (f3)
            F3_BEQ:  dec_d.alu_op = ALU_EQL;
            F3_BNE:  dec_d.alu_op = ALU_NEQ;
            F3_BLT:  dec_d.alu_op = ALU_SLT;
            F3_BGE:  dec_d.alu_op = ALU_GTE;
            F3_BLTU: dec_d.alu_op = ALU_SLTU;
            default: dec_d.alu_op = ALU_GTEU;
          endcase
          dec_d.is_branch = 1'b1;
          dec_d.illegal   = 1'b0;
        end
      end
      default: ;
    endcase
    dec_d.rd_we = dec_d.rd_we && (rd != 5'd0);
  end

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  // Output register: reset > flush > load > drain
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= DEC_RST;
      pc_q    <= RESET_PC;
      store_q <= '0;
      rd_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      dec_q   <= dec_d;
      pc_q    <= pc;
      store_q <= rs2_data;
      rd_q    <= rd;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign alu_op     = dec_q.alu_op;
  assign alu_in_1   = dec_q.in_1;
  assign alu_in_2   = dec_q.in_2;
  assign store_data = store_q;
  assign out_pc     = pc_q;
  assign rd_addr    = rd_q;
  assign rd_we      = dec_q.rd_we;
  assign is_branch  = dec_q.is_branch;
  assign mem_read   = dec_q.mem_read;
  assign mem_write  = dec_q.mem_write;
  assign illegal    = dec_q.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed vector table, handshake corner
// sequences, and a randomized run against an instruction-level model.
module tb_decode_issue_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_1, alu_in_2, store_data, out_pc;
  logic [4:0]  rd_addr;
  logic        rd_we, is_branch, mem_read, mem_write, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .store_data(store_data), .out_pc(out_pc), .rd_addr(rd_addr),
    .rd_we(rd_we), .is_branch(is_branch), .mem_read(mem_read),
    .mem_write(mem_write), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  op;
    logic [31:0] in1, in2;
    logic [4:0]  rd;
    logic        we, br, mr, mw, ill, chk_opnd;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] in1, in2, pc, sd;
    logic [4:0]  rd;
    logic        we, br, mr, mw, ill;
  } rec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, p, r1, r2, input logic [3:0] op,
                              input logic [31:0] a, b, input logic [4:0] rd,
                              input logic we, br, mr, mw, ill);
    vec_t v;
    v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.op = op; v.in1 = a; v.in2 = b;
    v.rd = rd; v.we = we; v.br = br; v.mr = mr; v.mw = mw; v.ill = ill; v.chk_opnd = !ill;
    return v;
  endfunction

  // Instruction-level reference: fields -> mnemonic class -> expected outputs
  function automatic rec_t ref_decode(input logic [31:0] i, p, r1, r2);
    rec_t   e;
    int     base_op[8]   = '{0, 5, 8, 9, 2, 6, 3, 4};
    int     branch_op[8] = '{10, 11, 15, 15, 8, 12, 9, 13};
    int     f3 = int'(i[14:12]);
    int     f7 = int'(i[31:25]);
    bit     shift = (f3 == 1) || (f3 == 5);
    bit     legal = 0;
    bit     writes = 0;
    logic signed [31:0] si = i;
    e.op = 15; e.in1 = r1; e.in2 = r2; e.pc = p; e.sd = r2; e.rd = i[11:7];
    e.br = 0; e.mr = 0; e.mw = 0;
    case (i[6:0])
      7'h33: begin
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        e.op  = 4'(base_op[f3] + ((f7 == 32) ? 1 : 0));
        e.in2 = shift ? (r2 % 32) : r2;
        writes = 1;
      end
      7'h13: begin
        legal = !shift || f7 == 0 || (f3 == 5 && f7 == 32);
        e.op  = 4'(base_op[f3] + ((shift && f7 == 32) ? 1 : 0));
        e.in2 = shift ? 32'(i[24:20]) : 32'(si >>> 20);
        writes = 1;
      end
      7'h37: begin legal = 1; writes = 1; e.op = 0; e.in1 = 0;  e.in2 = i & 32'hFFFF_F000; end
      7'h17: begin legal = 1; writes = 1; e.op = 0; e.in1 = p;  e.in2 = i & 32'hFFFF_F000; end
      7'h03: begin legal = 1; writes = 1; e.op = 0; e.in2 = 32'(si >>> 20); e.mr = 1; end
      7'h23: begin legal = 1; e.op = 0; e.in2 = (32'(si >>> 25) << 5) | 32'(i[11:7]); e.mw = 1; end
      7'h63: begin legal = (f3 != 2 && f3 != 3); e.op = 4'(branch_op[f3]); e.br = legal; end
      default: legal = 0;
    endcase
    if (!legal) begin
      e.op = 15; e.br = 0; e.mr = 0; e.mw = 0;
    end
    e.ill = !legal;
    e.we  = legal && writes && (i[11:7] != 0);
    return e;
  endfunction

  task automatic drive(input logic [31:0] i, p, r1, r2);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v);
    chk("vec.out_valid", 32'(out_valid), 1);
    chk("vec.alu_op", 32'(alu_op), 32'(v.op));
    chk("vec.illegal", 32'(illegal), 32'(v.ill));
    chk("vec.rd_we", 32'(rd_we), 32'(v.we));
    chk("vec.is_branch", 32'(is_branch), 32'(v.br));
    chk("vec.mem_read", 32'(mem_read), 32'(v.mr));
    chk("vec.mem_write", 32'(mem_write), 32'(v.mw));
    chk("vec.out_pc", out_pc, v.pc);
    chk("vec.store_data", store_data, v.rs2);
    if (v.chk_opnd) begin
      chk("vec.alu_in_1", alu_in_1, v.in1);
      chk("vec.alu_in_2", alu_in_2, v.in2);
      chk("vec.rd_addr", 32'(rd_addr), 32'(v.rd));
    end
  endtask

  vec_t vecs[14];
  rec_t exp_r;
  bit   exp_v;

  initial begin
    vecs[0]  = mk(32'h40208133, 32'h100, 32'd10, 32'd3, 4'd1, 32'd10, 32'd3, 5'd2, 1, 0, 0, 0, 0);
    vecs[1]  = mk(32'h40435293, 32'h104, 32'hF000_0000, 32'h55, 4'd7, 32'hF000_0000, 32'd4, 5'd5, 1, 0, 0, 0, 0);
    vecs[2]  = mk(32'hFFF00093, 32'h108, 32'd0, 32'd9, 4'd0, 32'd0, 32'hFFFF_FFFF, 5'd1, 1, 0, 0, 0, 0);
    vecs[3]  = mk(32'h0020F463, 32'h10C, 32'd7, 32'd8, 4'd13, 32'd7, 32'd8, 5'd8, 0, 1, 0, 0, 0);
    vecs[4]  = mk(32'h0000007F, 32'h110, 32'd1, 32'd2, 4'd15, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 1);
    vecs[5]  = mk(32'h00500013, 32'h114, 32'd0, 32'd0, 4'd0, 32'd0, 32'd5, 5'd0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(32'h123451B7, 32'h118, 32'hDEAD, 32'd0, 4'd0, 32'd0, 32'h1234_5000, 5'd3, 1, 0, 0, 0, 0);
    vecs[7]  = mk(32'hFFFFF217, 32'h100, 32'd1, 32'd0, 4'd0, 32'h100, 32'hFFFF_F000, 5'd4, 1, 0, 0, 0, 0);
    vecs[8]  = mk(32'hFFC32283, 32'h120, 32'h1000, 32'd0, 4'd0, 32'h1000, 32'hFFFF_FFFC, 5'd5, 1, 0, 1, 0, 0);
    vecs[9]  = mk(32'hFE742C23, 32'h124, 32'h2000, 32'hCAFE, 4'd0, 32'h2000, 32'hFFFF_FFF8, 5'd24, 0, 0, 0, 1, 0);
    vecs[10] = mk(32'h003110B3, 32'h128, 32'd1, 32'hFFFF_FF25, 4'd5, 32'd1, 32'd5, 5'd1, 1, 0, 0, 0, 0);
    vecs[11] = mk(32'h0020A463, 32'h12C, 32'd1, 32'd2, 4'd15, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 1);
    vecs[12] = mk(32'h02009093, 32'h130, 32'd1, 32'd2, 4'd15, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 1);
    vecs[13] = mk(32'hFFF13093, 32'h134, 32'd3, 32'd0, 4'd9, 32'd3, 32'hFFFF_FFFF, 5'd1, 1, 0, 0, 0, 0);

    rst = 1; in_valid = 0; flush = 0; out_ready = 1;
    drive(0, 0, 0, 0);

    // Reset for two cycles, with flush and in_valid asserted to show reset wins
    in_valid = 1; flush = 1; drive(32'h40208133, 32'h44, 1, 2);
    repeat (2) tick();
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_pc", out_pc, RST_PC);
    chk("rst.alu_in_1", alu_in_1, 0);
    rst = 0; in_valid = 0; flush = 0;
    tick();
    chk("post_rst.out_valid", 32'(out_valid), 0);
    chk("post_rst.alu_op", 32'(alu_op), 14);
    chk("post_rst.in_ready", 32'(in_ready), 1);
    chk("post_rst.rd_we", 32'(rd_we), 0);

    // Directed vector table, one transfer per entry
    for (int k = 0; k < 14; k++) begin
      in_valid = 1; out_ready = 1;
      drive(vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
      tick();
      check_vec(vecs[k]);
    end
    in_valid = 0;
    tick();
    chk("drain.out_valid", 32'(out_valid), 0);

    // Stall: SUB held while ADDI waits three cycles
    in_valid = 1; out_ready = 1; drive(vecs[0].instr, vecs[0].pc, vecs[0].rs1, vecs[0].rs2);
    tick();
    out_ready = 0; drive(vecs[2].instr, vecs[2].pc, vecs[2].rs1, vecs[2].rs2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.in_ready", 32'(in_ready), 0);
      chk("stall.out_valid", 32'(out_valid), 1);
      chk("stall.alu_op", 32'(alu_op), 1);
      chk("stall.alu_in_1", alu_in_1, 10);
      chk("stall.out_pc", out_pc, vecs[0].pc);
    end
    out_ready = 1;
    #1 chk("stall.release_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    check_vec(vecs[2]);
    tick();
    chk("stall.no_dup", 32'(out_valid), 0);

    // Flush alongside an accepted transfer drops it
    in_valid = 1; flush = 1; drive(vecs[6].instr, vecs[6].pc, vecs[6].rs1, vecs[6].rs2);
    tick();
    chk("flush.xfer_dropped", 32'(out_valid), 0);
    flush = 0;
    tick();
    chk("flush.reload_valid", 32'(out_valid), 1);
    chk("flush.reload_op", alu_in_2, 32'h1234_5000);
    // Flush during a stall clears the held instruction
    in_valid = 0; out_ready = 0; flush = 1;
    tick();
    chk("flush.stall_cleared", 32'(out_valid), 0);
    flush = 0; out_ready = 1;

    // Randomized traffic against the reference model
    exp_v = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] ri;
      logic [6:0]  opcs[8] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h7F};
      logic        rdy_e;
      ri = $urandom;
      ri[6:0] = opcs[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) ri[6:0] = 7'($urandom);
      case ($urandom_range(0, 3))
        0: ri[31:25] = 7'h00;
        1: ri[31:25] = 7'h20;
        default: ;
      endcase
      drive(ri, $urandom, $urandom, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rdy_e = !exp_v || out_ready;
      #1 chk("rnd.in_ready", 32'(in_ready), 32'(rdy_e));
      if (flush) exp_v = 0;
      else if (in_valid && rdy_e) begin
        exp_v = 1;
        exp_r = ref_decode(instr, pc, rs1_data, rs2_data);
      end else if (out_ready) exp_v = 0;
      tick();
      chk("rnd.out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rnd.alu_op", 32'(alu_op), 32'(exp_r.op));
        chk("rnd.illegal", 32'(illegal), 32'(exp_r.ill));
        chk("rnd.rd_we", 32'(rd_we), 32'(exp_r.we));
        chk("rnd.is_branch", 32'(is_branch), 32'(exp_r.br));
        chk("rnd.mem_read", 32'(mem_read), 32'(exp_r.mr));
        chk("rnd.mem_write", 32'(mem_write), 32'(exp_r.mw));
        chk("rnd.out_pc", out_pc, exp_r.pc);
        chk("rnd.store_data", store_data, exp_r.sd);
        chk("rnd.rd_addr", 32'(rd_addr), 32'(exp_r.rd));
        if (!exp_r.ill) begin
          chk("rnd.alu_in_1", alu_in_1, exp_r.in1);
          chk("rnd.alu_in_2", alu_in_2, exp_r.in2);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
